matmul_seq_engine: RTL

//  Sequential matrix-multiply engine: C[i][j] = sum_k A[i][k]*B[k][j] for A (num_i x num_k), B (num_k x num_j).

---
 rtl/matmul_seq_engine.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/matmul_seq_engine.sv
// matmul_seq_engine
// Sequential matrix-multiply engine computing C[i][j] = sum_k A[i][k]*B[k][j].
// Loop order is i (outer), j (middle), k (inner). For each (i,j) the engine
// issues num_k reads on a dual-read memory, accumulates the returning
// products and writes one C element.
//
// Optional build macro: ACC_SAT_EN
//   defined   -> product and accumulate saturate at 2^DW-1
//   undefined -> product and accumulate wrap modulo 2^DW
// Timing is identical in both builds.
//
// Handshake: start is a request sampled only while the FSM is IDLE; it is
// accepted on the rising edge where start=1 and state=IDLE. busy is high
// from the cycle after acceptance through the last C write, and done pulses
// for exactly one cycle after that (busy=0 during done). start seen in any
// other state is ignored. err is registered at acceptance (set when any
// dimension is zero) and holds until the next accepted start.
//
// Memory interface: rd_en strobes both read ports; rd_data_a/rd_data_b are
// valid exactly MEM_LAT cycles after the corresponding rd_en. wr_en is a
// single-cycle write strobe with wr_addr/wr_data valid in the same cycle.

module matmul_seq_engine #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int DIM_W   = 8,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic [AW-1:0]    addr_c,
  input  logic [DIM_W-1:0] num_i,
  input  logic [DIM_W-1:0] num_k,
  input  logic [DIM_W-1:0] num_j,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr_a,
  output logic [AW-1:0]    rd_addr_b,
  input  logic [DW-1:0]    rd_data_a,
  input  logic [DW-1:0]    rd_data_b,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Job configuration latched at the accepted start
  logic [AW-1:0]    base_a_q, base_a_d;
  logic [AW-1:0]    base_b_q, base_b_d;
  logic [AW-1:0]    base_c_q, base_c_d;
  logic [DIM_W-1:0] dim_i_q, dim_i_d;
  logic [DIM_W-1:0] dim_k_q, dim_k_d;
  logic [DIM_W-1:0] dim_j_q, dim_j_d;

  // Loop counters, accumulator and sticky error
  logic [DIM_W-1:0] i_q, i_d;
  logic [DIM_W-1:0] j_q, j_d;
  logic [DIM_W-1:0] k_q, k_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic             err_q, err_d;

  // In-flight read tags: valid, first (k=0) and last (k=num_k-1)
  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [MEM_LAT-1:0] first_q, first_d;
  logic [MEM_LAT-1:0] last_q, last_d;

  // Decoded helper conditions
  logic zero_dim;
  logic k_last;
  logic j_last;
  logic elem_last;
  logic issue;
  logic ret_vld;
  logic ret_first;
  logic ret_last;

  // Arithmetic
  logic [DW-1:0] prod;
  logic [DW-1:0] sum;
`ifdef ACC_SAT_EN
  logic [2*DW-1:0] prod_full;
  logic [DW:0]     sum_full;
`endif

  // Decode of the loop-end and return-tag conditions
  always_comb begin
    zero_dim  = (num_i == '0) || (num_k == '0) || (num_j == '0);
    k_last    = (k_q == dim_k_q - DIM_W'(1));
    j_last    = (j_q == dim_j_q - DIM_W'(1));
    elem_last = j_last && (i_q == dim_i_q - DIM_W'(1));
    issue     = (state_q == S_ISSUE);
    ret_vld   = vld_q[MEM_LAT-1];
    ret_first = first_q[MEM_LAT-1];
    ret_last  = last_q[MEM_LAT-1];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the i/j/k loop sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = zero_dim ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (k_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ret_vld && ret_last) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = elem_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state
  always_comb begin
    rd_en     = (state_q == S_ISSUE);
    wr_en     = (state_q == S_WRITE);
    busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

  // Product and accumulate, wrapping or saturating depending on the build
  always_comb begin
`ifdef ACC_SAT_EN
    prod_full = rd_data_a * rd_data_b;
    prod      = (|prod_full[2*DW-1:DW]) ? {DW{1'b1}} : prod_full[DW-1:0];
    sum_full  = {1'b0, acc_q} + {1'b0, prod};
    sum       = sum_full[DW] ? {DW{1'b1}} : sum_full[DW-1:0];
`else
    prod = rd_data_a * rd_data_b;
    sum  = acc_q + prod;
`endif
  end

  // Next values for configuration, counters, tags and accumulator
  always_comb begin
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    dim_i_d  = dim_i_q;
    dim_k_d  = dim_k_q;
    dim_j_d  = dim_j_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    err_d    = err_q;

    // Latch the job on the accepted start
    if (state_q == S_IDLE && start) begin
      base_a_d = addr_a;
      base_b_d = addr_b;
      base_c_d = addr_c;
      dim_i_d  = num_i;
      dim_k_d  = num_k;
      dim_j_d  = num_j;
      i_d      = '0;
      j_d      = '0;
      k_d      = '0;
      err_d    = zero_dim;
    end

    // Inner k loop walks one read per cycle
    if (state_q == S_ISSUE) begin
      k_d = k_last ? '0 : k_q + DIM_W'(1);
    end

    // After the write, step j then i; park at zero after the last element
    if (state_q == S_WRITE) begin
      if (elem_last) begin
        i_d = '0;
        j_d = '0;
      end else if (j_last) begin
        j_d = '0;
        i_d = i_q + DIM_W'(1);
      end else begin
        j_d = j_q + DIM_W'(1);
      end
    end

    // Tag shift registers track each read until its data returns
    vld_d[0]   = issue;
    first_d[0] = issue && (k_q == '0);
    last_d[0]  = issue && k_last;
    for (int n = 1; n < MEM_LAT; n++) begin
      vld_d[n]   = vld_q[n-1];
      first_d[n] = first_q[n-1];
      last_d[n]  = last_q[n-1];
    end

    // The k=0 return seeds the accumulator, later returns add into it
    acc_d = acc_q;
    if (ret_vld) begin
      acc_d = ret_first ? prod : sum;
    end
  end

  // Datapath registers; reset aborts any job in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      dim_i_q  <= '0;
      dim_k_q  <= '0;
      dim_j_q  <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
      vld_q    <= '0;
      first_q  <= '0;
      last_q   <= '0;
    end else begin
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      dim_i_q  <= dim_i_d;
      dim_k_q  <= dim_k_d;
      dim_j_q  <= dim_j_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      first_q  <= first_d;
      last_q   <= last_d;
    end
  end

  // Address generation and write data straight from the loop counters
  always_comb begin
    rd_addr_a = base_a_q + ((AW'(i_q) * AW'(dim_k_q) + AW'(k_q)) << 2);
    rd_addr_b = base_b_q + ((AW'(k_q) * AW'(dim_j_q) + AW'(j_q)) << 2);
    wr_addr   = base_c_q + ((AW'(i_q) * AW'(dim_j_q) + AW'(j_q)) << 2);
    wr_data   = acc_q;
    err       = err_q;
  end

endmodule
